// File: rtl/iccm_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : iccm_boot_ctrl
//  Purpose  : Boot-time ICCM loader. On reset it samples a load strap. In
//             load mode it assembles little-endian 32-bit words from a UART
//             byte stream and writes them to consecutive ICCM word addresses
//             until a terminator word arrives. It then releases the core,
//             which fetches through a combinational pass-through port.
//             Running past the end of the ICCM parks the block in an error
//             state that holds the core in reset.
//
//  Ports    : clk_i, rst_ni              clock, asynchronous active-low reset
//             prog_en_i                  load-mode strap, sampled in BOOT
//             rx_valid_i, rx_byte_i      UART byte stream
//             f_req_i, f_addr_i          fetch request from the SRAM adapter
//             f_gnt_o, f_rdata_o,
//             f_rvalid_o                 fetch grant / return
//             mem_req_o, mem_we_o,
//             mem_addr_o, mem_wdata_o    ICCM request
//             mem_rdata_i, mem_rvalid_i  ICCM read return
//             core_rst_no                core reset hold (0 = held)
//             done_o, err_o              load finished / load overflow
//             word_cnt_o                 number of words written
//
//  Revision : 1.0 - initial release
// ============================================================================
module iccm_boot_ctrl #(
   parameter int unsigned AW       = 12,
   parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          prog_en_i,
   input  logic          rx_valid_i,
   input  logic [7:0]    rx_byte_i,
   input  logic          f_req_i,
   input  logic [AW-1:0] f_addr_i,
   output logic          f_gnt_o,
   output logic [31:0]   f_rdata_o,
   output logic          f_rvalid_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i,
   input  logic          mem_rvalid_i,
   output logic          core_rst_no,
   output logic          done_o,
   output logic          err_o,
   output logic [AW:0]   word_cnt_o
);

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WRITE = 3'd2,
      ST_RUN   = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic [31:0]   asm_q, asm_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          core_rst_n_q, core_rst_n_d;

   logic          byte_accept;
   logic          word_complete;
   logic          cnt_full;

   // Bytes are taken in WRITE as well as LOAD so a byte landing in the
   // write cycle becomes byte 0 of the next word instead of being lost.
   assign byte_accept   = rx_valid_i && ((state_q == ST_LOAD) || (state_q == ST_WRITE));
   assign word_complete = byte_accept && (bcnt_q == 2'd3);
   // The count's MSB is set only when all 2**AW words have been written.
   assign cnt_full      = cnt_q[AW];

   always_comb begin
      state_d      = state_q;
      bcnt_d       = bcnt_q;
      asm_d        = asm_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      done_d       = done_q;
      err_d        = err_q;
      core_rst_n_d = (state_q == ST_RUN);

      f_gnt_o      = 1'b0;
      f_rdata_o    = 32'd0;
      f_rvalid_o   = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;

      if (byte_accept) begin
         bcnt_d = bcnt_q + 2'd1;
         case (bcnt_q)
            2'd0: asm_d[7:0]   = rx_byte_i;
            2'd1: asm_d[15:8]  = rx_byte_i;
            2'd2: asm_d[23:16] = rx_byte_i;
            default: begin
               asm_d[31:24] = rx_byte_i;
               // Separate copy so the next word can start assembling while
               // this one is being written.
               wdata_d      = {rx_byte_i, asm_q[23:0]};
            end
         endcase
      end

      case (state_q)
         ST_BOOT: begin
            state_d = prog_en_i ? ST_LOAD : ST_RUN;
         end
         ST_LOAD: begin
            if (word_complete) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // Terminator takes priority over the overflow check, so a full
            // ICCM followed by the terminator still completes cleanly.
            if (wdata_q == END_WORD) begin
               done_d  = 1'b1;
               state_d = ST_RUN;
            end else if (cnt_full) begin
               err_d   = 1'b1;
               state_d = ST_ERR;
            end else begin
               mem_req_o  = 1'b1;
               mem_we_o   = 1'b1;
               mem_addr_o = cnt_q[AW-1:0];
               cnt_d      = cnt_q + (AW+1)'(1);
               state_d    = ST_LOAD;
            end
         end
         ST_RUN: begin
            mem_req_o  = f_req_i;
            mem_addr_o = f_addr_i;
            f_gnt_o    = 1'b1;
            f_rdata_o  = mem_rdata_i;
            f_rvalid_o = mem_rvalid_i;
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_BOOT;
         bcnt_q       <= 2'd0;
         asm_q        <= 32'd0;
         wdata_q      <= 32'd0;
         cnt_q        <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         core_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bcnt_q       <= bcnt_d;
         asm_q        <= asm_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         done_q       <= done_d;
         err_q        <= err_d;
         core_rst_n_q <= core_rst_n_d;
      end
   end

   assign mem_wdata_o = wdata_q;
   assign core_rst_no = core_rst_n_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign word_cnt_o  = cnt_q;

endmodule
`default_nettype wire
